// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline memory-access stage with ack timeout and sticky error
module mem_access_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 3,
  parameter int TIMEOUT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_W-1:0]  rd,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic              flush,
  input  logic              err_clr,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_rd,
  output logic              err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state;
  logic [CW-1:0]    tcount;
  logic [REG_W-1:0] lat_rd;
  logic             lat_reg_write;

  // upstream must hold while a memory access is outstanding
  assign stall_out = (state == ACCESS);

  // stage FSM: accept in IDLE, wait for ack or timeout in ACCESS; wb_valid pulses one cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      tcount        <= '0;
      lat_rd        <= '0;
      lat_reg_write <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      wb_valid      <= 1'b0;
      wb_we         <= 1'b0;
      wb_data       <= '0;
      wb_rd         <= '0;
      err           <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      // clear first so a same-cycle set below takes precedence
      if (err_clr) err <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in && !flush) begin
            if (mem_read && mem_write) begin
              // illegal combination: report and retire without touching memory
              err      <= 1'b1;
              wb_valid <= 1'b1;
              wb_we    <= 1'b0;
              wb_rd    <= rd;
              wb_data  <= alu_result;
            end else if (mem_read || mem_write) begin
              mem_addr      <= alu_result;
              mem_wdata     <= store_data;
              mem_we        <= mem_write;
              mem_req       <= 1'b1;
              lat_rd        <= rd;
              lat_reg_write <= reg_write;
              tcount        <= '0;
              state         <= ACCESS;
            end else begin
              wb_valid <= 1'b1;
              wb_data  <= alu_result;
              wb_rd    <= rd;
              wb_we    <= reg_write && (rd != '0);
            end
          end
        end
        ACCESS: begin
          if (flush) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= IDLE;
          end else if (mem_ack) begin
            // ack wins over a coinciding timeout
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= lat_rd;
            state    <= IDLE;
            if (mem_we) begin
              wb_we   <= 1'b0;
              wb_data <= mem_addr;
            end else begin
              wb_we   <= lat_reg_write && (lat_rd != '0);
              wb_data <= mem_rdata;
            end
          end else if (tcount == TLAST) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            err      <= 1'b1;
            wb_valid <= 1'b1;
            wb_we    <= 1'b0;
            wb_rd    <= lat_rd;
            wb_data  <= mem_addr;
            state    <= IDLE;
          end else begin
            tcount <= tcount + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed scoreboard bench for mem_access_stage
module tb_mem_access_stage;

  logic        clock;
  logic        reset;
  logic        valid_in;
  logic [15:0] alu_result;
  logic [15:0] store_data;
  logic [2:0]  rd;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        flush;
  logic        err_clr;
  logic        stall_out;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        wb_valid;
  logic        wb_we;
  logic [15:0] wb_data;
  logic [2:0]  wb_rd;
  logic        err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [2:0]  rd;
    logic [15:0] data;
    bit          chk_data;
  } exp_t;

  exp_t sb[$];

  mem_access_stage #(.DATA_W(16), .REG_W(3), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .alu_result(alu_result),
    .store_data(store_data), .rd(rd), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .flush(flush), .err_clr(err_clr), .stall_out(stall_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_data(wb_data), .wb_rd(wb_rd), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    flush     = 1'b0;
    err_clr   = 1'b0;
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] s, input logic [2:0] r,
                       input logic rdn, input logic wrn, input logic rw);
    valid_in   = 1'b1;
    alu_result = a;
    store_data = s;
    rd         = r;
    mem_read   = rdn;
    mem_write  = wrn;
    reg_write  = rw;
  endtask

  task automatic push(input logic we, input logic [2:0] r, input logic [15:0] d, input bit cd);
    exp_t e;
    e.we = we;
    e.rd = r;
    e.data = d;
    e.chk_data = cd;
    sb.push_back(e);
  endtask

  // every writeback pulse must match the oldest expected entry
  always @(posedge clock) begin
    #1;
    if (wb_valid === 1'b1) begin
      chk("wb_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_we", 32'(wb_we), 32'(e.we));
        chk("wb_rd", 32'(wb_rd), 32'(e.rd));
        if (e.chk_data) chk("wb_data", 32'(wb_data), 32'(e.data));
      end
    end
  end

  initial begin
    int cyc;
    reset = 1'b1;
    idle_inputs();
    alu_result = '0;
    store_data = '0;
    rd         = '0;
    mem_rdata  = '0;
    mem_ack    = 1'b0;
    tick();
    tick();
    chk("rst_stall", 32'(stall_out), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_wb_data", 32'(wb_data), 0);

    // ALU op accepted on the first edge after reset release
    reset = 1'b0;
    issue(16'h002D, 16'h0000, 3'd3, 1'b0, 1'b0, 1'b1);
    push(1'b1, 3'd3, 16'h002D, 1'b1);
    tick();
    chk("alu_stall", 32'(stall_out), 0);
    idle_inputs();
    tick();

    // load, ack in third ACCESS cycle; valid_in held with junk must be ignored
    issue(16'h0075, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b1);
    push(1'b1, 3'd2, 16'hBEEF, 1'b1);
    tick();
    issue(16'hFFFF, 16'hFFFF, 3'd6, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("ld_stall", 32'(stall_out), 1);
      chk("ld_req", 32'(mem_req), 1);
      chk("ld_we", 32'(mem_we), 0);
      chk("ld_addr", 32'(mem_addr), 32'h0075);
      if (i == 2) begin
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
      end
      tick();
    end
    idle_inputs();
    mem_ack = 1'b0;
    chk("ld_done_req", 32'(mem_req), 0);
    chk("ld_done_stall", 32'(stall_out), 0);
    tick();

    // store, ack after one cycle
    issue(16'h001D, 16'h1234, 3'd5, 1'b0, 1'b1, 1'b1);
    push(1'b0, 3'd5, 16'h001D, 1'b1);
    tick();
    idle_inputs();
    chk("st_req", 32'(mem_req), 1);
    chk("st_we", 32'(mem_we), 1);
    chk("st_wdata", 32'(mem_wdata), 32'h1234);
    chk("st_addr", 32'(mem_addr), 32'h001D);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("st_done_req", 32'(mem_req), 0);
    tick();

    // timeout: eight ACCESS cycles then error writeback
    issue(16'h0040, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b1);
    push(1'b0, 3'd1, 16'h0000, 1'b0);
    tick();
    idle_inputs();
    cyc = 0;
    while (stall_out === 1'b1 && cyc < 20) begin
      cyc++;
      tick();
    end
    chk("to_cycles", 32'(cyc), 8);
    chk("to_req", 32'(mem_req), 0);
    chk("to_err", 32'(err), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("errclr", 32'(err), 0);

    // ack coinciding with timeout cycle counts as success
    issue(16'h0050, 16'h0000, 3'd7, 1'b1, 1'b0, 1'b1);
    push(1'b1, 3'd7, 16'h5A5A, 1'b1);
    tick();
    idle_inputs();
    for (int i = 0; i < 7; i++) tick();
    chk("ack_to_stall", 32'(stall_out), 1);
    mem_ack   = 1'b1;
    mem_rdata = 16'h5A5A;
    tick();
    mem_ack = 1'b0;
    chk("ack_to_err", 32'(err), 0);
    chk("ack_to_stall2", 32'(stall_out), 0);

    // flush in ACCESS cycle 2 with ack: no writeback
    issue(16'h0060, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b1);
    tick();
    idle_inputs();
    tick();
    flush   = 1'b1;
    mem_ack = 1'b1;
    tick();
    flush   = 1'b0;
    mem_ack = 1'b0;
    chk("fl_stall", 32'(stall_out), 0);
    chk("fl_req", 32'(mem_req), 0);
    tick();

    // flush in IDLE discards the instruction
    issue(16'h0011, 16'h0000, 3'd4, 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    tick();
    idle_inputs();
    tick();

    // rd=0 ALU op never writes
    issue(16'h0022, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1);
    push(1'b0, 3'd0, 16'h0022, 1'b1);
    tick();
    idle_inputs();

    // read+write together: error, no request; err_clr same cycle loses
    issue(16'h0033, 16'h0000, 3'd4, 1'b1, 1'b1, 1'b1);
    err_clr = 1'b1;
    push(1'b0, 3'd4, 16'h0000, 1'b0);
    tick();
    idle_inputs();
    chk("both_req", 32'(mem_req), 0);
    chk("both_err", 32'(err), 1);
    chk("both_stall", 32'(stall_out), 0);

    // stray ack in IDLE is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_req", 32'(mem_req), 0);

    // reset mid-ACCESS clears everything at once
    issue(16'h0077, 16'h0000, 3'd3, 1'b1, 1'b0, 1'b1);
    tick();
    idle_inputs();
    tick();
    chk("pre_rst_stall", 32'(stall_out), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mrst_stall", 32'(stall_out), 0);
    chk("mrst_req", 32'(mem_req), 0);
    chk("mrst_we", 32'(mem_we), 0);
    chk("mrst_addr", 32'(mem_addr), 0);
    chk("mrst_wdata", 32'(mem_wdata), 0);
    chk("mrst_wbv", 32'(wb_valid), 0);
    chk("mrst_wbwe", 32'(wb_we), 0);
    chk("mrst_wbdata", 32'(wb_data), 0);
    chk("mrst_wbrd", 32'(wb_rd), 0);
    chk("mrst_err", 32'(err), 0);
    mem_ack = 1'b1;
    tick();
    reset   = 1'b0;
    tick();
    mem_ack = 1'b0;
    tick();
    tick();

    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the ALU result and memory data width.
REQ-002 The block SHALL have parameter REG_W, default 3, meaning the destination-register index width.
REQ-003 The block SHALL have parameter TIMEOUT, default 8, meaning the maximum ACCESS cycles to wait for mem_ack.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset; all state SHALL change on the rising clock edge, except on reset.
REQ-005 The block SHALL have the following ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- valid_in  in  1  the execute stage presents an instruction.
- alu_result  in  DATA_W  ALU output; the memory address for loads and stores.
- store_data  in  DATA_W  store operand.
- rd  in  REG_W  destination register.
- mem_read, mem_write, reg_write  in  1 each  control bits.
- flush  in  1  kill the in-flight instruction.
- err_clr  in  1  clear the sticky error flag.
- stall_out  out  1  upstream holds its inputs while this is high.
- mem_req, mem_we  out  1 each  memory request and write enable.
- mem_addr, mem_wdata  out  DATA_W  memory address and write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_ack  in  1  memory completion.
- wb_valid, wb_we  out  1 each  writeback strobe and register-write enable.
- wb_data  out  DATA_W  writeback data.
- wb_rd  out  REG_W  writeback destination register.
- err  out  1  sticky error flag.

Function
REQ-006 FSM states SHALL be IDLE and ACCESS; stall_out SHALL equal (state == ACCESS), combinationally.
REQ-007 Inputs SHALL be sampled only in IDLE when valid_in=1; valid_in SHALL be ignored in ACCESS.
REQ-008 IDLE with valid_in=1 and mem_read=mem_write=0 (ALU op) SHALL register the result next edge: wb_valid=1, wb_data=alu_result, wb_rd=rd, wb_we=reg_write, for 1-cycle latency.
REQ-009 IDLE with valid_in=1 and exactly one of mem_read/mem_write SHALL perform these actions next edge: latch mem_addr=alu_result, mem_wdata=store_data, mem_we=mem_write; latch rd/reg_write; set mem_req=1; clear the timeout counter; enter ACCESS.
REQ-010 In ACCESS, mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable until the edge at which mem_ack=1 is sampled.
REQ-011 On mem_ack=1 in ACCESS, the next edge SHALL perform these actions: mem_req=0; wb_valid=1; state IDLE. For a read, wb_data=mem_rdata and wb_we=latched reg_write. For a write, wb_we=0 and wb_data=latched address.
REQ-012 Each ACCESS cycle without mem_ack SHALL increment the timeout counter; when the counter equals TIMEOUT-1 with no ack, the next edge SHALL perform these actions: mem_req=0; err=1; wb_valid=1 with wb_we=0; state IDLE.
REQ-013 mem_ack in the same cycle as the timeout condition SHALL be treated as success (REQ-011), with err unchanged.
REQ-014 valid_in with mem_read=mem_write=1 SHALL issue no memory request and SHALL set err=1; the next edge SHALL give wb_valid=1 with wb_we=0.
REQ-015 wb_we SHALL be forced to 0 whenever the destination register is 0.
REQ-016 wb_valid SHALL be a single-cycle pulse; it SHALL be 0 on every cycle with no completion.
REQ-017 flush=1 in IDLE SHALL discard that cycle's valid_in, with no wb_valid.
REQ-018 flush=1 in ACCESS SHALL have mem_req=0 and state IDLE at the next edge, with no wb_valid, including when mem_ack=1 in the same cycle.
REQ-019 err SHALL be sticky; err_clr SHALL clear it next edge; a set condition in the same cycle as err_clr SHALL win.
REQ-020 mem_ack received while in IDLE SHALL be ignored.

Reset
REQ-021 reset=1 SHALL immediately force the following values: state IDLE; stall_out=0; mem_req=0; mem_we=0; wb_valid=0; wb_we=0; err=0; timeout counter 0; mem_addr, mem_wdata, wb_data and wb_rd all 0.
REQ-022 reset asserted in ACCESS SHALL abandon the access, with no wb_valid after release.
REQ-023 The first valid_in SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-024 ALU op: valid_in, alu_result=0x002D, rd=3, reg_write=1 -> one cycle later wb_valid=1, wb_data=0x002D, wb_rd=3, wb_we=1, and stall_out stays 0.
REQ-025 Load: alu_result=0x0075, mem_read, rd=2; mem_ack after 3 cycles with mem_rdata=0xBEEF -> mem_addr=0x0075 held, stall_out=1 throughout ACCESS, then wb_data=0xBEEF, wb_we=1.
REQ-026 Store: alu_result=0x001D, store_data=0x1234, mem_write; mem_ack after 1 cycle -> mem_we=1, mem_wdata=0x1234, then wb_valid=1, wb_we=0.
REQ-027 Timeout: load with mem_ack held low and TIMEOUT=8 -> 8 ACCESS cycles, then mem_req=0, err=1, wb_valid=1, wb_we=0; err_clr then gives err=0.
REQ-028 Flush and reset: flush in ACCESS cycle 2 coincident with mem_ack -> no wb_valid and IDLE next cycle; reset mid-ACCESS -> all outputs 0 immediately, with no wb_valid afterwards.
REQ-029 Corner cases: rd=0 ALU op with reg_write=1 -> wb_we=0; mem_read=mem_write=1 -> no mem_req, err=1.
